exit_boot_ctrl: RTL

On-chip OBI-slave peripheral that is the SoC-side endpoint of the testbench exit and boot-strap signals. Firmware writes an exit code and triggers termination. The block then waits a programmable drain period, so UART/stdout traffic can flush, before it raises `exit_valid_o`/`exit_value_o` toward the harness. It also latches the `boot_select_i`/`execute_from_flash_i` straps once after reset and exposes them, together with a free-running cycle counter, to software.

---
 rtl/exit_boot_ctrl.sv | 137 +++++++++++++
 1 files changed

// File: rtl/exit_boot_ctrl.sv
// OBI-slave endpoint for harness exit/boot straps: exit code with drain delay,
// one-shot strap capture and a free-running cycle counter for software.
module exit_boot_ctrl #(
    parameter logic [15:0] DRAIN_DEFAULT = 16'd64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        boot_select_i,
    input  logic        execute_from_flash_i,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        boot_select_o,
    output logic        execute_from_flash_o,
    output logic        exit_valid_o,
    output logic [31:0] exit_value_o
);

    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_e;

    localparam logic [2:0] REG_EXIT_VALUE  = 3'd0;
    localparam logic [2:0] REG_EXIT_CTRL   = 3'd1;
    localparam logic [2:0] REG_DRAIN       = 3'd2;
    localparam logic [2:0] REG_BOOT_STATUS = 3'd3;
    localparam logic [2:0] REG_CYCLE_COUNT = 3'd4;

    state_e      state_q, state_d;
    logic [15:0] drain_cnt_q, drain_cnt_d;
    logic [15:0] drain_cycles_q, drain_cycles_d;
    logic [31:0] exit_value_q, exit_value_d;
    logic [31:0] cycle_cnt_q;
    logic        boot_select_q, execute_from_flash_q, strap_valid_q;
    logic        rvalid_q;
    logic [31:0] rdata_q, rdata_d;

    logic [2:0]  sel;
    logic        wr, rd, trigger;
    logic        unused_addr;

    assign sel         = addr_i[4:2];
    assign wr          = req_i & we_i;
    assign rd          = req_i & ~we_i;
    assign trigger     = wr && (sel == REG_EXIT_CTRL) && be_i[0] && wdata_i[0];
    assign unused_addr = ^{addr_i[31:5], addr_i[1:0]};

    assign gnt_o                = req_i;
    assign rvalid_o             = rvalid_q;
    assign rdata_o              = rdata_q;
    assign boot_select_o        = boot_select_q;
    assign execute_from_flash_o = execute_from_flash_q;
    assign exit_valid_o         = (state_q == DONE);
    assign exit_value_o         = exit_value_q;

    // Configuration registers are only writable in RUN so the exit code freezes at trigger.
    always_comb begin
        state_d        = state_q;
        drain_cnt_d    = drain_cnt_q;
        exit_value_d   = exit_value_q;
        drain_cycles_d = drain_cycles_q;
        case (state_q)
            RUN: begin
                if (wr && sel == REG_EXIT_VALUE) begin
                    for (int i = 0; i < 4; i++) begin
                        if (be_i[i]) exit_value_d[8*i +: 8] = wdata_i[8*i +: 8];
                    end
                end
                if (wr && sel == REG_DRAIN) begin
                    if (be_i[0]) drain_cycles_d[7:0]  = wdata_i[7:0];
                    if (be_i[1]) drain_cycles_d[15:8] = wdata_i[15:8];
                end
                if (trigger) begin
                    state_d     = DRAIN;
                    drain_cnt_d = drain_cycles_q;
                end
            end
            DRAIN: begin
                if (drain_cnt_q == 16'd0) state_d = DONE;
                else                      drain_cnt_d = drain_cnt_q - 16'd1;
            end
            DONE:    state_d = DONE;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        rdata_d = 32'd0;
        if (rd) begin
            case (sel)
                REG_EXIT_VALUE:  rdata_d = exit_value_q;
                REG_EXIT_CTRL:   rdata_d = {30'd0, state_q == DONE, state_q == DRAIN};
                REG_DRAIN:       rdata_d = {16'd0, drain_cycles_q};
                REG_BOOT_STATUS: rdata_d = {29'd0, strap_valid_q, execute_from_flash_q, boot_select_q};
                REG_CYCLE_COUNT: rdata_d = cycle_cnt_q;
                default:         rdata_d = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= RUN;
            drain_cnt_q    <= 16'd0;
            drain_cycles_q <= DRAIN_DEFAULT;
            exit_value_q   <= 32'd0;
            cycle_cnt_q    <= 32'd0;
            rvalid_q       <= 1'b0;
            rdata_q        <= 32'd0;
        end else begin
            state_q        <= state_d;
            drain_cnt_q    <= drain_cnt_d;
            drain_cycles_q <= drain_cycles_d;
            exit_value_q   <= exit_value_d;
            cycle_cnt_q    <= cycle_cnt_q + 32'd1;
            rvalid_q       <= req_i;
            rdata_q        <= rdata_d;
        end
    end

    // Straps are sampled exactly once, on the first edge out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            boot_select_q        <= 1'b0;
            execute_from_flash_q <= 1'b0;
            strap_valid_q        <= 1'b0;
        end else if (!strap_valid_q) begin
            boot_select_q        <= boot_select_i;
            execute_from_flash_q <= execute_from_flash_i;
            strap_valid_q        <= 1'b1;
        end
    end

endmodule
